// File: rtl/prim_stream_ser_pkg.sv
// Shared types and helpers for the wide-to-narrow stream serializer.
package prim_stream_ser_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ser_state_e;

    // Beat counter needs at least one bit even when a word is a single beat.
    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/prim_stream_ser.sv
// Splits each IN_WIDTH upstream word into IN_WIDTH/OUT_WIDTH downstream beats,
// with zero-bubble handoff between consecutive words.
module prim_stream_ser
    import prim_stream_ser_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 urdy_o,
    input  logic                 uvld_i,
    input  logic [IN_WIDTH-1:0]  udat_i,
    input  logic                 drdy_i,
    output logic                 dvld_o,
    output logic [OUT_WIDTH-1:0] ddat_o,
    output logic                 dlast_o
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CW    = cnt_width(RATIO);
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    if ((OUT_WIDTH < 1) || (IN_WIDTH < OUT_WIDTH) || (IN_WIDTH % OUT_WIDTH != 0)) begin : g_bad_params
        $error("prim_stream_ser: IN_WIDTH must be a positive multiple of OUT_WIDTH");
    end

    ser_state_e           state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;
    logic [IN_WIDTH-1:0]  word;
    logic                 at_last;
    logic                 up_beat;
    logic                 dn_beat;

    function automatic logic [OUT_WIDTH-1:0] slice(input logic [IN_WIDTH-1:0] w,
                                                   input logic [CW-1:0] i);
        int idx;
        idx = (LSB_FIRST != 0) ? int'(i) : (RATIO - 1 - int'(i));
        return w[idx*OUT_WIDTH +: OUT_WIDTH];
    endfunction

    assign at_last = (cnt == LAST_IDX);
    assign cnt_nxt = cnt + CW'(1);
    assign up_beat = uvld_i && urdy_o;
    assign dn_beat = dvld_o && drdy_i;

    // Only the last beat lets a new word in, and only if that beat leaves this cycle.
    always_comb begin
        urdy_o = 1'b0;
        if (!reset) begin
            if (state == ST_IDLE) urdy_o = 1'b1;
            else if (at_last)     urdy_o = drdy_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            word    <= '0;
            dvld_o  <= 1'b0;
            dlast_o <= 1'b0;
            ddat_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (up_beat) begin
                        state   <= ST_BUSY;
                        word    <= udat_i;
                        cnt     <= '0;
                        dvld_o  <= 1'b1;
                        ddat_o  <= slice(udat_i, '0);
                        dlast_o <= (RATIO == 1);
                    end
                end
                ST_BUSY: begin
                    if (dn_beat) begin
                        if (!at_last) begin
                            cnt     <= cnt_nxt;
                            ddat_o  <= slice(word, cnt_nxt);
                            dlast_o <= (cnt_nxt == LAST_IDX);
                        end else if (up_beat) begin
                            word    <= udat_i;
                            cnt     <= '0;
                            ddat_o  <= slice(udat_i, '0);
                            dlast_o <= (RATIO == 1);
                        end else begin
                            state   <= ST_IDLE;
                            cnt     <= '0;
                            dvld_o  <= 1'b0;
                            dlast_o <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prim_stream_ser.sv
// Three serializer configurations driven with shared stimulus and checked
// every cycle against a per-instance queue of expected beats.
module tb_prim_stream_ser;

    logic        clk = 1'b0;
    logic        reset;
    logic        uvld;
    logic [31:0] udat;
    logic        drdy;

    logic       urdy_l, dvld_l, dlast_l;
    logic [7:0] ddat_l;
    logic       urdy_m, dvld_m, dlast_m;
    logic [7:0] ddat_m;
    logic       urdy_r, dvld_r, dlast_r;
    logic [7:0] ddat_r;

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    // Expected beats per instance: {last, data}
    logic [8:0] q [3][$];

    always #5 clk = ~clk;

    prim_stream_ser #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .reset(reset), .urdy_o(urdy_l), .uvld_i(uvld), .udat_i(udat),
        .drdy_i(drdy), .dvld_o(dvld_l), .ddat_o(ddat_l), .dlast_o(dlast_l));

    prim_stream_ser #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(0)) u_msb (
        .clk(clk), .reset(reset), .urdy_o(urdy_m), .uvld_i(uvld), .udat_i(udat),
        .drdy_i(drdy), .dvld_o(dvld_m), .ddat_o(ddat_m), .dlast_o(dlast_m));

    prim_stream_ser #(.IN_WIDTH(8), .OUT_WIDTH(8), .LSB_FIRST(1)) u_r1 (
        .clk(clk), .reset(reset), .urdy_o(urdy_r), .uvld_i(uvld), .udat_i(udat[7:0]),
        .drdy_i(drdy), .dvld_o(dvld_r), .ddat_o(ddat_r), .dlast_o(dlast_r));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Compare one instance against its queue, then apply the transfers that
    // the coming rising edge will perform.
    task automatic mon(input int k, input int ratio, input bit lsb, input logic [31:0] w,
                       input logic urdy, input logic dvld, input logic [7:0] dat, input logic last);
        bit exp_v, exp_r;
        int idx;
        exp_v = (q[k].size() != 0);
        exp_r = !reset && (q[k].size() == 0 || (q[k].size() == 1 && drdy));
        chk($sformatf("urdy%0d", k), {31'b0, urdy}, {31'b0, exp_r});
        chk($sformatf("dvld%0d", k), {31'b0, dvld}, {31'b0, exp_v});
        if (exp_v) begin
            chk($sformatf("ddat%0d", k),  {24'b0, dat},  {24'b0, q[k][0][7:0]});
            chk($sformatf("dlast%0d", k), {31'b0, last}, {31'b0, q[k][0][8]});
        end else begin
            chk($sformatf("dlast_idle%0d", k), {31'b0, last}, 32'b0);
        end
        if (reset) begin
            q[k].delete();
        end else begin
            if (exp_v && drdy) void'(q[k].pop_front());
            if (uvld && exp_r) begin
                for (int i = 0; i < ratio; i++) begin
                    idx = lsb ? i : ratio - 1 - i;
                    q[k].push_back({(i == ratio - 1), w[idx*8 +: 8]});
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, 4, 1'b1, udat, urdy_l, dvld_l, ddat_l, dlast_l);
            mon(1, 4, 1'b0, udat, urdy_m, dvld_m, ddat_m, dlast_m);
            mon(2, 1, 1'b1, {24'b0, udat[7:0]}, urdy_r, dvld_r, ddat_r, dlast_r);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a word on the upstream port until the LSB-first instance takes it.
    task automatic send(input logic [31:0] w);
        bit taken;
        taken = 1'b0;
        uvld = 1'b1;
        udat = w;
        for (int t = 0; t < 50 && !taken; t++) begin
            @(negedge clk);
            taken = urdy_l;
            step();
        end
        if (!taken) chk("send_timeout", 32'd0, 32'd1);
        uvld = 1'b0;
    endtask

    initial begin
        reset = 1'b1; uvld = 1'b0; udat = '0; drdy = 1'b0;
        step();
        mon_en = 1'b1;
        uvld = 1'b1; udat = 32'hFFFF_FFFF;
        step(); step();
        uvld = 1'b0; reset = 1'b0;
        step();

        // Single words, full-rate drain
        drdy = 1'b1;
        send(32'hDDCCBBAA);
        repeat (5) step();
        send(32'h11223344);
        repeat (5) step();

        // Back-to-back words must stream without a gap
        send(32'h03020100);
        send(32'h07060504);
        repeat (5) step();

        // Downstream stall on the third beat
        send(32'hDDCCBBAA);
        step(); step();
        drdy = 1'b0;
        repeat (3) step();
        chk("stall_hold", {24'b0, ddat_l}, 32'hCC);
        chk("stall_urdy", {31'b0, urdy_l}, 32'd0);
        drdy = 1'b1;
        repeat (4) step();

        // Reset mid-word discards the rest; next word restarts at slice 0
        send(32'hDDCCBBAA);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_dvld", {31'b0, dvld_l}, 32'd0);
        send(32'h44332211);
        chk("post_rst_first", {24'b0, ddat_l}, 32'h11);
        repeat (5) step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            uvld  = ($urandom_range(0, 3) != 0);
            udat  = $urandom;
            drdy  = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end

        reset = 1'b0; uvld = 1'b0; drdy = 1'b1;
        repeat (12) step();
        for (int k = 0; k < 3; k++) chk($sformatf("drain%0d", k), q[k].size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
